// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults and constants for the scoreboarded register file
package regfile_sb_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_REG     = 0;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits, set by reserve, cleared by committed write
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_reg_i,
  input  logic                rsv_en_i,
  input  logic [ADDR_W-1:0]   rsv_reg_i,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  // reserve beats a same-cycle write to the same register; register 0 is never busy
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++)
      busy_d[i] = (i == ZERO_REG) ? 1'b0 :
                  (rsv_en_i && rsv_reg_i == ADDR_W'(i)) ? 1'b1 :
                  (wr_en_i && wr_reg_i == ADDR_W'(i)) ? 1'b0 : busy_q[i];
  end
  // busy state register, reset drops any pending reserve or clear
  always_ff @(posedge clock) busy_q <= ctrl_reset ? '0 : busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read one-write register file with write-through bypass and busy scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                ctrl_writeEnable,
  input  logic [ADDR_W-1:0]   ctrl_writeReg,
  input  logic [DATA_W-1:0]   data_writeReg,
  input  logic [ADDR_W-1:0]   ctrl_readRegA,
  input  logic [ADDR_W-1:0]   ctrl_readRegB,
  output logic [DATA_W-1:0]   data_readRegA,
  output logic [DATA_W-1:0]   data_readRegB,
  input  logic                ctrl_reserveEnable,
  input  logic [ADDR_W-1:0]   ctrl_reserveReg,
  output logic                busy_readRegA,
  output logic                busy_readRegB,
  output logic [NUM_REGS-1:0] busy_vector
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] mux_a, mux_b;
  logic              hit_a, hit_b;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] data_q, data_d;
      assign data_d = (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(g)) ? data_writeReg : data_q;
      // write-enabled storage word, cleared by reset
      always_ff @(posedge clock) data_q <= ctrl_reset ? '0 : data_d;
      assign regs[g] = data_q;
    end
  end
  // AND-OR read mux driven by decoded address selects
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mux_a = mux_a | ({DATA_W{ctrl_readRegA == ADDR_W'(i)}} & regs[i]);
      mux_b = mux_b | ({DATA_W{ctrl_readRegB == ADDR_W'(i)}} & regs[i]);
    end
  end
  assign hit_a = ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA && ctrl_readRegA != ADDR_W'(ZERO_REG);
  assign hit_b = ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB && ctrl_readRegB != ADDR_W'(ZERO_REG);
  assign data_readRegA = hit_a ? data_writeReg : mux_a;
  assign data_readRegB = hit_b ? data_writeReg : mux_b;
  assign busy_readRegA = busy_vector[ctrl_readRegA] & ~hit_a;
  assign busy_readRegB = busy_vector[ctrl_readRegB] & ~hit_b;
  regfile_sb_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .wr_en_i    (ctrl_writeEnable),
    .wr_reg_i   (ctrl_writeReg),
    .rsv_en_i   (ctrl_reserveEnable),
    .rsv_reg_i  (ctrl_reserveReg),
    .busy_o     (busy_vector)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks on a 32x32 instance, randomised model comparison on an 8x16 instance
module tb_regfile_sb;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic ctrl_reset;
  logic        b_we, b_re, b_ba, b_bb;
  logic [4:0]  b_wr, b_rr, b_ra, b_rb;
  logic [31:0] b_wd, b_da, b_db, b_bv;
  logic        s_we, s_re, s_ba, s_bb;
  logic [2:0]  s_wr, s_rr, s_ra, s_rb;
  logic [15:0] s_wd, s_da, s_db;
  logic [7:0]  s_bv;
  int total = 0;
  int bad = 0;

  regfile_sb u_big (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(b_we), .ctrl_writeReg(b_wr), .data_writeReg(b_wd),
    .ctrl_readRegA(b_ra), .ctrl_readRegB(b_rb), .data_readRegA(b_da), .data_readRegB(b_db),
    .ctrl_reserveEnable(b_re), .ctrl_reserveReg(b_rr),
    .busy_readRegA(b_ba), .busy_readRegB(b_bb), .busy_vector(b_bv)
  );

  regfile_sb #(.DATA_W(16), .NUM_REGS(8)) u_small (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wr), .data_writeReg(s_wd),
    .ctrl_readRegA(s_ra), .ctrl_readRegB(s_rb), .data_readRegA(s_da), .data_readRegB(s_db),
    .ctrl_reserveEnable(s_re), .ctrl_reserveReg(s_rr),
    .busy_readRegA(s_ba), .busy_readRegB(s_bb), .busy_vector(s_bv)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    #1;
    total++; if (b_bv !== 32'h0) begin bad++; $display("FAIL reset_bv got %h want 0", b_bv); end
    for (int i = 0; i < 32; i++) begin
      b_ra = 5'(i);
      b_rb = 5'(31 - i);
      #1;
      total++; if (b_da !== 32'h0 || b_db !== 32'h0) begin bad++; $display("FAIL reset_data r%0d got %h/%h want 0", i, b_da, b_db); end
      total++; if (b_ba !== 1'b0 || b_bb !== 1'b0) begin bad++; $display("FAIL reset_busy r%0d got %b/%b want 0", i, b_ba, b_bb); end
    end
    b_we = 1'b1; b_wr = 5'd0; b_wd = 32'hDEADBEEF; b_ra = 5'd0; b_rb = 5'd0;
    #1;
    total++; if (b_da !== 32'h0) begin bad++; $display("FAIL r0_nobypass got %h want 0", b_da); end
    tick();
    b_we = 1'b0;
    #1;
    total++; if (b_da !== 32'h0 || b_db !== 32'h0) begin bad++; $display("FAIL r0_write got %h/%h want 0", b_da, b_db); end
  endtask

  task automatic test_bypass();
    b_we = 1'b1; b_wr = 5'd5; b_wd = 32'h12345678; b_ra = 5'd5; b_rb = 5'd6;
    #1;
    total++; if (b_da !== 32'h12345678) begin bad++; $display("FAIL bypass_a got %h want 12345678", b_da); end
    total++; if (b_db !== 32'h0) begin bad++; $display("FAIL bypass_b_other got %h want 0", b_db); end
    tick();
    b_we = 1'b0; b_rb = 5'd5;
    #1;
    total++; if (b_da !== 32'h12345678 || b_db !== 32'h12345678) begin bad++; $display("FAIL stored_r5 got %h/%h want 12345678", b_da, b_db); end
  endtask

  task automatic test_reserve_clear();
    b_re = 1'b1; b_rr = 5'd7; b_rb = 5'd7;
    #1;
    total++; if (b_bb !== 1'b0) begin bad++; $display("FAIL rsv_same_cycle got %b want 0", b_bb); end
    tick();
    b_re = 1'b0;
    tick();
    total++; if (b_bv[7] !== 1'b1 || b_bb !== 1'b1) begin bad++; $display("FAIL rsv_busy got %b/%b want 1/1", b_bv[7], b_bb); end
    b_re = 1'b1; b_rr = 5'd7;
    tick();
    b_re = 1'b0;
    #1;
    total++; if (b_bv !== 32'h80) begin bad++; $display("FAIL rsv_idem got %h want 80", b_bv); end
    b_we = 1'b1; b_wr = 5'd7; b_wd = 32'hA5;
    #1;
    total++; if (b_bb !== 1'b0 || b_db !== 32'hA5) begin bad++; $display("FAIL wr_busy_bypass got %b/%h want 0/a5", b_bb, b_db); end
    tick();
    b_we = 1'b0;
    #1;
    total++; if (b_bv[7] !== 1'b0 || b_db !== 32'hA5) begin bad++; $display("FAIL wr_clear got %b/%h want 0/a5", b_bv[7], b_db); end
  endtask

  task automatic test_write_reserve_same();
    b_we = 1'b1; b_wr = 5'd9; b_wd = 32'hCAFE0009; b_re = 1'b1; b_rr = 5'd9;
    tick();
    b_we = 1'b1; b_wr = 5'd10; b_wd = 32'h0A; b_re = 1'b1; b_rr = 5'd11; b_ra = 5'd9; b_rb = 5'd9;
    #1;
    total++; if (b_bv[9] !== 1'b1 || b_ba !== 1'b1 || b_bb !== 1'b1) begin bad++; $display("FAIL wr_rsv_busy got %b%b%b want 111", b_bv[9], b_ba, b_bb); end
    total++; if (b_da !== 32'hCAFE0009 || b_db !== 32'hCAFE0009) begin bad++; $display("FAIL wr_rsv_data got %h/%h want cafe0009", b_da, b_db); end
    tick();
    b_we = 1'b0; b_re = 1'b1; b_rr = 5'd0; b_ra = 5'd10;
    tick();
    b_re = 1'b0;
    #1;
    total++; if (b_bv !== 32'h0A00) begin bad++; $display("FAIL diff_regs_bv got %h want 00000a00", b_bv); end
    total++; if (b_da !== 32'h0A) begin bad++; $display("FAIL diff_regs_data got %h want a", b_da); end
  endtask

  task automatic test_reset_priority();
    b_we = 1'b1; b_wr = 5'd4; b_wd = 32'h77;
    tick();
    b_ra = 5'd4;
    #1;
    total++; if (b_da !== 32'h77) begin bad++; $display("FAIL pre_reset_r4 got %h want 77", b_da); end
    ctrl_reset = 1'b1; b_re = 1'b1; b_rr = 5'd3; b_we = 1'b1; b_wr = 5'd4; b_wd = 32'h55;
    tick();
    ctrl_reset = 1'b0; b_re = 1'b0; b_we = 1'b0;
    #1;
    total++; if (b_bv !== 32'h0) begin bad++; $display("FAIL rst_prio_bv got %h want 0", b_bv); end
    total++; if (b_da !== 32'h0) begin bad++; $display("FAIL rst_prio_r4 got %h want 0", b_da); end
  endtask

  task automatic test_random();
    logic [15:0] mem [8];
    logic [7:0]  bsy;
    logic [15:0] ea, eb;
    logic        eba, ebb;
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    bsy = 8'h0;
    for (int c = 0; c < 10000; c++) begin
      ctrl_reset = ($urandom_range(0, 199) == 0);
      s_we = 1'($urandom_range(0, 1));
      s_wr = 3'($urandom_range(0, 7));
      s_wd = 16'($urandom);
      s_re = ($urandom_range(0, 2) == 0);
      s_rr = ($urandom_range(0, 3) == 0) ? s_wr : 3'($urandom_range(0, 7));
      s_ra = ($urandom_range(0, 3) == 0) ? s_wr : 3'($urandom_range(0, 7));
      s_rb = ($urandom_range(0, 3) == 0) ? s_ra : 3'($urandom_range(0, 7));
      #1;
      ea  = (s_ra == 0) ? 16'h0 : (s_we && s_wr == s_ra) ? s_wd : mem[s_ra];
      eb  = (s_rb == 0) ? 16'h0 : (s_we && s_wr == s_rb) ? s_wd : mem[s_rb];
      eba = (s_ra != 0) && bsy[s_ra] && !(s_we && s_wr == s_ra);
      ebb = (s_rb != 0) && bsy[s_rb] && !(s_we && s_wr == s_rb);
      total++; if (s_da !== ea) begin bad++; $display("FAIL rnd_data_a cyc %0d got %h want %h", c, s_da, ea); end
      total++; if (s_db !== eb) begin bad++; $display("FAIL rnd_data_b cyc %0d got %h want %h", c, s_db, eb); end
      total++; if (s_ba !== eba) begin bad++; $display("FAIL rnd_busy_a cyc %0d got %b want %b", c, s_ba, eba); end
      total++; if (s_bb !== ebb) begin bad++; $display("FAIL rnd_busy_b cyc %0d got %b want %b", c, s_bb, ebb); end
      total++; if (s_bv !== bsy) begin bad++; $display("FAIL rnd_bv cyc %0d got %h want %h", c, s_bv, bsy); end
      tick();
      if (ctrl_reset) begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        bsy = 8'h0;
      end else begin
        if (s_we && s_wr != 0) begin
          mem[s_wr] = s_wd;
          bsy[s_wr] = 1'b0;
        end
        if (s_re && s_rr != 0) bsy[s_rr] = 1'b1;
      end
    end
    ctrl_reset = 1'b0; s_we = 1'b0; s_re = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    b_we = 1'b0; b_wr = '0; b_wd = '0; b_ra = '0; b_rb = '0; b_re = 1'b0; b_rr = '0;
    s_we = 1'b0; s_wr = '0; s_wd = '0; s_ra = '0; s_rb = '0; s_re = 1'b0; s_rr = '0;
    test_reset();
    test_bypass();
    test_reserve_clear();
    test_write_reserve_same();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
